mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: MULT_OP  in  1  start signed multiply; sampled in IDLE only.
REQ-004 SHALL have port: DIV_OP  in  1  start signed divide; sampled in IDLE only.
REQ-005 SHALL have port: A  in  32  multiplicand / dividend (register A value).
REQ-006 SHALL have port: B  in  32  multiplier / divisor (register B value).
REQ-007 SHALL have port: HI_out  out  32  product upper word / remainder.
REQ-008 SHALL have port: LO_out  out  32  product lower word / quotient.
REQ-009 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port: done  out  1  one-cycle pulse, HI_out/LO_out valid.
REQ-011 SHALL have port: div_zero  out  1  one-cycle divide-by-zero flag.

Function
REQ-012 SHALL implement FSM states IDLE, MULT_RUN, DIV_RUN, FINISH.
REQ-013 SHALL, in IDLE on an edge with MULT_OP=1, capture A/B, load the 5-bit iteration counter with 31, and enter MULT_RUN.
REQ-014 SHALL, in IDLE on an edge with DIV_OP=1 and MULT_OP=0, capture |A|, |B| and both sign bits, load the counter with 31, and enter DIV_RUN.
REQ-015 SHALL give MULT_OP priority when MULT_OP and DIV_OP are both high.
REQ-016 SHALL ignore MULT_OP/DIV_OP while busy=1; captured operands SHALL NOT change mid-operation.
REQ-017 SHALL perform one radix-2 Booth step per edge in MULT_RUN over a 65-bit {HI,LO,q-1} register, giving the exact 64-bit two's-complement product.
REQ-018 SHALL perform one restoring shift/subtract step per edge in DIV_RUN on the magnitudes.
REQ-019 SHALL, on the edge where the counter is 0 in a RUN state, perform the final (32nd) step and enter FINISH.
REQ-020 SHALL, on the FINISH edge, write HI_out/LO_out, assert done for exactly one cycle, and return to IDLE; start-to-done latency is 33 edges.
REQ-021 SHALL place product[63:32] in HI_out and product[31:0] in LO_out for multiply.
REQ-022 SHALL truncate divide toward zero: quotient negated when sign(A)^sign(B)=1, remainder carries sign(A); LO_out=quotient, HI_out=remainder.
REQ-023 SHALL return LO_out=0x80000000, HI_out=0 for 0x80000000 / 0xFFFFFFFF (wrap, no flag).
REQ-024 SHALL hold HI_out/LO_out stable between done pulses.

Reset
REQ-025 SHALL, when reset=1 on an edge, force state IDLE, counter 0, and HI_out, LO_out, busy, done, div_zero to 0.
REQ-026 SHALL abort any in-flight operation on reset with no done pulse; reset dominates MULT_OP/DIV_OP on the same edge.

Configuration
REQ-027 SHALL, with MULTDIV_DIVZERO_EN defined, check B==0 at DIV_OP capture, go directly to FINISH, leave HI_out/LO_out unchanged, and pulse done and div_zero together for one cycle (latency 2 edges).
REQ-028 SHALL, without MULTDIV_DIVZERO_EN, tie div_zero to 0 and run the full 32-step divide; raw quotient magnitude is 0xFFFFFFFF and raw remainder is |A|, then REQ-022 sign rules apply.

Verification
REQ-029 SHALL cover: MULT_OP, A=6, B=0xFFFFFFF9 (-7) -> done 33 edges later, HI_out=0xFFFFFFFF, LO_out=0xFFFFFFD6.
REQ-030 SHALL cover: MULT_OP, A=B=0x7FFFFFFF -> HI_out=0x3FFFFFFF, LO_out=0x00000001.
REQ-031 SHALL cover: DIV_OP, A=0xFFFFFFF9 (-7), B=2 -> LO_out=0xFFFFFFFD, HI_out=0xFFFFFFFF; DIV_OP, A=0x80000000, B=0xFFFFFFFF -> LO_out=0x80000000, HI_out=0.
REQ-032 SHALL cover: DIV_OP, A=7, B=0 -> with macro: done=div_zero=1 on the 2nd edge, HI/LO unchanged; without macro: done at 33 edges, LO_out=0xFFFFFFFF, HI_out=7, div_zero=0.
REQ-033 SHALL cover: MULT_OP and DIV_OP together, then a new MULT_OP pulsed at edge 5 -> multiply result only, one done pulse, and the second request ignored.
REQ-034 SHALL cover: reset asserted at edge 10 of a multiply -> next cycle busy=0, HI_out=LO_out=0, and no done pulse; a following MULT_OP completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring, truncating) unit.
// Optional macro MULTDIV_DIVZERO_EN: short-circuit divide-by-zero with a div_zero flag.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        MULT_OP,
    input  logic        DIV_OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [64:0] prod_q;          // {hi, lo, q-1}
    logic [31:0] mcand_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        is_div_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
`ifdef MULTDIV_DIVZERO_EN
    logic        dz_q;
    logic        div_zero_q;
`endif

    logic [32:0] booth_sum;
    logic [64:0] prod_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign a_mag = A[31] ? -A : A;
    assign b_mag = B[31] ? -B : B;

    // Upper word kept 33 bits wide so subtracting 0x80000000 cannot overflow.
    always_comb begin
        booth_sum = {prod_q[64], prod_q[64:33]};
        case (prod_q[1:0])
            2'b01:   booth_sum = {prod_q[64], prod_q[64:33]} + {mcand_q[31], mcand_q};
            2'b10:   booth_sum = {prod_q[64], prod_q[64:33]} - {mcand_q[31], mcand_q};
            default: booth_sum = {prod_q[64], prod_q[64:33]};
        endcase
        prod_next = {booth_sum, prod_q[32:1]};
    end

    // Extra headroom bit so a zero divisor still reads as "subtract succeeded".
    always_comb begin
        div_shift = {rem_q, quo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (MULT_OP) begin
                    state_d = MULT_RUN;
                end else if (DIV_OP) begin
`ifdef MULTDIV_DIVZERO_EN
                    state_d = (B == 32'd0) ? FINISH : DIV_RUN;
`else
                    state_d = DIV_RUN;
`endif
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= 5'd0;
            prod_q     <= 65'd0;
            mcand_q    <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (MULT_OP) begin
                        mcand_q  <= A;
                        prod_q   <= {32'd0, B, 1'b0};
                        cnt_q    <= 5'd31;
                        is_div_q <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
                        dz_q     <= 1'b0;
`endif
                    end else if (DIV_OP) begin
                        sign_a_q <= A[31];
                        sign_b_q <= B[31];
                        quo_q    <= a_mag;
                        dvs_q    <= b_mag;
                        rem_q    <= 32'd0;
                        cnt_q    <= 5'd31;
                        is_div_q <= 1'b1;
`ifdef MULTDIV_DIVZERO_EN
                        dz_q     <= (B == 32'd0);
`endif
                    end
                end
                MULT_RUN: begin
                    prod_q <= prod_next;
                    cnt_q  <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                end
                DIV_RUN: begin
                    rem_q <= div_diff[33] ? div_shift[31:0] : div_diff[31:0];
                    quo_q <= {quo_q[30:0], ~div_diff[33]};
                    cnt_q <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                end
                FINISH: begin
                    done_q <= 1'b1;
`ifdef MULTDIV_DIVZERO_EN
                    if (dz_q) begin
                        div_zero_q <= 1'b1;
                    end else
`endif
                    if (is_div_q) begin
                        lo_q <= (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                        hi_q <= sign_a_q ? -rem_q : rem_q;
                    end else begin
                        hi_q <= prod_q[64:33];
                        lo_q <= prod_q[32:1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign done   = done_q;
`ifdef MULTDIV_DIVZERO_EN
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; capture edge counts as edge 1.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MULT_OP = 1'b0;
    logic        DIV_OP = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail = 0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .MULT_OP  (MULT_OP),
        .DIV_OP   (DIV_OP),
        .A        (A),
        .B        (B),
        .HI_out   (HI_out),
        .LO_out   (LO_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    // Drives a request for exactly one capture edge, then scrambles A/B.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        MULT_OP = m;
        DIV_OP  = d;
        A       = a;
        B       = b;
        @(posedge clock);
        #1;
        MULT_OP = 1'b0;
        DIV_OP  = 1'b0;
        A       = 32'hDEADBEEF;
        B       = 32'h12345678;
    endtask

    // Returns the edge number at which done is first seen, or -1 on timeout.
    task automatic wait_done(input int first, output int edge_at);
        edge_at = -1;
        for (int i = first; i <= first + 45; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                edge_at = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({HI_out, LO_out} !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b dz=%b, want all 0",
                     HI_out, LO_out, busy, done, div_zero);
        end
        $display("reset: HI=%h LO=%h busy=%b done=%b", HI_out, LO_out, busy, done);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mult(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int e;
        issue(1'b1, 1'b0, a, b);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_busy: got %b want 1", busy);
        end
        wait_done(2, e);
        n_checks++;
        if (e !== 34) begin
            n_fail++;
            $display("FAIL mult_latency: got edge %0d want 34", e);
        end
        n_checks++;
        if (HI_out !== exp_hi || LO_out !== exp_lo || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_result %h*%h: got %h_%h dz=%b want %h_%h dz=0",
                     a, b, HI_out, LO_out, div_zero, exp_hi, exp_lo);
        end
        $display("mult %h * %h -> HI=%h LO=%h at edge %0d", a, b, HI_out, LO_out, e);
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || HI_out !== exp_hi || LO_out !== exp_lo) begin
            n_fail++;
            $display("FAIL mult_hold: got done=%b busy=%b %h_%h want 0 0 %h_%h",
                     done, busy, HI_out, LO_out, exp_hi, exp_lo);
        end
    endtask

    task automatic test_div(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int e;
        issue(1'b0, 1'b1, a, b);
        wait_done(2, e);
        n_checks++;
        if (e !== 34) begin
            n_fail++;
            $display("FAIL div_latency: got edge %0d want 34", e);
        end
        n_checks++;
        if (HI_out !== exp_hi || LO_out !== exp_lo || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_result %h/%h: got rem=%h quo=%h dz=%b want rem=%h quo=%h dz=0",
                     a, b, HI_out, LO_out, div_zero, exp_hi, exp_lo);
        end
        $display("div %h / %h -> HI=%h LO=%h at edge %0d", a, b, HI_out, LO_out, e);
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL div_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_div_zero();
        int e;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = HI_out;
        prev_lo = LO_out;
        issue(1'b0, 1'b1, 32'd7, 32'd0);
        wait_done(2, e);
`ifdef MULTDIV_DIVZERO_EN
        n_checks++;
        if (e !== 2 || div_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL divzero_flag: got edge %0d dz=%b want edge 2 dz=1", e, div_zero);
        end
        n_checks++;
        if (HI_out !== prev_hi || LO_out !== prev_lo) begin
            n_fail++;
            $display("FAIL divzero_hold: got %h_%h want %h_%h", HI_out, LO_out, prev_hi, prev_lo);
        end
`else
        n_checks++;
        if (e !== 34 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL divzero_flag: got edge %0d dz=%b want edge 34 dz=0", e, div_zero);
        end
        n_checks++;
        if (HI_out !== 32'd7 || LO_out !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divzero_raw: got %h_%h want 00000007_ffffffff", HI_out, LO_out);
        end
`endif
        $display("div 7 / 0 -> HI=%h LO=%h dz=%b at edge %0d", HI_out, LO_out, div_zero, e);
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL divzero_pulse: got done=%b dz=%b want 0 0", done, div_zero);
        end
    endtask

    task automatic test_simultaneous();
        int e;
        int extra;
        issue(1'b1, 1'b1, 32'd3, 32'd5);
        repeat (3) @(posedge clock);
        @(negedge clock);
        MULT_OP = 1'b1;
        A       = 32'd100;
        B       = 32'd100;
        @(posedge clock);
        #1;
        MULT_OP = 1'b0;
        wait_done(6, e);
        n_checks++;
        if (e !== 34 || HI_out !== 32'd0 || LO_out !== 32'd15) begin
            n_fail++;
            $display("FAIL simul_result: got edge %0d %h_%h want edge 34 00000000_0000000f",
                     e, HI_out, LO_out);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_single_done: got %0d extra pulses busy=%b want 0 0", extra, busy);
        end
        $display("simultaneous ops -> HI=%h LO=%h extra_done=%0d", HI_out, LO_out, extra);
    endtask

    task automatic test_reset_abort();
        int pulses;
        issue(1'b1, 1'b0, 32'd6, 32'hFFFFFFF9);
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b %h_%h done=%b want 0 0_0 0",
                     busy, HI_out, LO_out, done);
        end
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
        end
        $display("reset abort -> busy=%b HI=%h LO=%h pulses=%0d", busy, HI_out, LO_out, pulses);
    endtask

    initial begin
        test_reset();
        test_mult(32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);
        test_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
        test_mult(32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        test_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_div(32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        test_div(32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
        test_div_zero();
        test_simultaneous();
        test_reset_abort();
        test_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
